// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle executor for br/jr/jal, downstream of the CON flip-flop.
// Define BRANCH_SEQ_LINK_EN to enable jr/jal; otherwise only br executes and jr/jal are illegal.
module branch_sequencer #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] ra_data,
    input  logic              con,
    output logic              con_in,
    output logic [3:0]        ra_sel,
    output logic              ra_out,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data,
    output logic              taken,
    output logic              err,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JAL = 5'b10011;
    localparam logic [4:0] OP_JR  = 5'b10100;

    typedef enum logic [1:0] {IDLE, EVAL, DECIDE, UPDATE} state_t;

    state_t            state;
    state_t            state_next;
    logic [4:0]        op_q;
    logic [3:0]        ra_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] br_target;
    logic [4:0]        ir_op;
    logic              ir_legal;

    assign ir_op     = ir[31:27];
    assign br_target = pc_q + {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};

`ifdef BRANCH_SEQ_LINK_EN
    logic [DATA_W-1:0] target_q;
    logic              unused_bits;

    assign ir_legal    = (ir_op == OP_BR) || (ir_op == OP_JAL) || (ir_op == OP_JR);
    assign unused_bits = ^ir[22:OFF_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= '0;
        end else if (state == EVAL) begin
            target_q <= ra_data;
        end
    end
`else
    logic unused_bits;

    assign ir_legal    = (ir_op == OP_BR);
    assign unused_bits = ^{ir[22:OFF_W], ra_data, OP_JAL, OP_JR};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal opcodes skip straight to UPDATE so done still comes back to the control unit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ir_legal ? EVAL : UPDATE;
                end
            end
            EVAL:    state_next = (op_q == OP_BR) ? DECIDE : UPDATE;
            DECIDE:  state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            ra_q  <= '0;
            off_q <= '0;
            pc_q  <= '0;
            taken <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= ir_op;
                        ra_q  <= ir[26:23];
                        off_q <= ir[OFF_W-1:0];
                        pc_q  <= pc_in;
                        taken <= 1'b0;
                        err   <= !ir_legal;
                    end
                end
                EVAL: begin
                    if (op_q != OP_BR) begin
                        taken <= 1'b1;
                    end
                end
                DECIDE:  taken <= con;
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state only, so reset clears every strobe and data bus at once.
    always_comb begin
        con_in    = 1'b0;
        ra_sel    = '0;
        ra_out    = 1'b0;
        pc_load   = 1'b0;
        pc_out    = '0;
        link_we   = 1'b0;
        link_data = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            EVAL: begin
                ra_sel = ra_q;
                ra_out = 1'b1;
                con_in = (op_q == OP_BR);
            end
            UPDATE: begin
                done = 1'b1;
                if (!err) begin
                    if (op_q == OP_BR) begin
                        pc_load = taken;
                        pc_out  = taken ? br_target : '0;
                    end
`ifdef BRANCH_SEQ_LINK_EN
                    else begin
                        pc_load = 1'b1;
                        pc_out  = target_q;
                        if (op_q == OP_JAL) begin
                            link_we   = 1'b1;
                            link_data = pc_q;
                        end
                    end
`endif
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: table-driven vectors with a scoreboard queue, plus hand-written
// sequences for held start and reset mid-instruction. Honours BRANCH_SEQ_LINK_EN.
`timescale 1ns/1ps
module tb_branch_sequencer;

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JAL = 5'b10011;
    localparam logic [4:0] OP_JR  = 5'b10100;
`ifdef BRANCH_SEQ_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] ir;
    logic [31:0] pc_in;
    logic [31:0] ra_data;
    logic        con;
    logic        con_in;
    logic [3:0]  ra_sel;
    logic        ra_out;
    logic        pc_load;
    logic [31:0] pc_out;
    logic        link_we;
    logic [31:0] link_data;
    logic        taken;
    logic        err;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.DATA_W(32), .OFF_W(19)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ir(ir), .pc_in(pc_in),
        .ra_data(ra_data), .con(con), .con_in(con_in), .ra_sel(ra_sel), .ra_out(ra_out),
        .pc_load(pc_load), .pc_out(pc_out), .link_we(link_we), .link_data(link_data),
        .taken(taken), .err(err), .busy(busy), .done(done)
    );

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  ra;
        logic [18:0] off;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        c;
        int          lat;
        logic        load;
        logic [31:0] pc_exp;
        logic        lwe;
        logic [31:0] link_exp;
        logic        tkn;
        logic        er;
    } vec_t;

    typedef struct {
        int          idx;
        int          lat;
        int          pulses;
        logic [3:0]  ra;
        logic        load;
        logic [31:0] pc_exp;
        logic        lwe;
        logic [31:0] link_exp;
        logic        tkn;
        logic        er;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    function automatic vec_t mk(logic [4:0] op, logic [3:0] ra, logic [18:0] off,
                                logic [31:0] pc, logic [31:0] rd, logic c, int lat,
                                logic load, logic [31:0] pce, logic lwe, logic [31:0] lnk,
                                logic tk, logic er);
        vec_t v;
        v.op = op; v.ra = ra; v.off = off; v.pc = pc; v.rdata = rd; v.c = c;
        v.lat = lat; v.load = load; v.pc_exp = pce; v.lwe = lwe; v.link_exp = lnk;
        v.tkn = tk; v.er = er;
        return v;
    endfunction

    task automatic check(input string what, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", what, idx, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        ir      = {v.op, v.ra, 2'b00, 2'b00, v.off};
        pc_in   = v.pc;
        ra_data = v.rdata;
        con     = v.c;
        start   = 1'b1;
        e.idx = idx; e.lat = v.lat; e.ra = v.ra; e.load = v.load; e.pc_exp = v.pc_exp;
        e.lwe = v.lwe; e.link_exp = v.link_exp; e.tkn = v.tkn; e.er = v.er;
        e.pulses = (v.op == OP_BR) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        int   cyc = 0;
        int   pulses = 0;
        logic got_done = 1'b0;
        e = sb.pop_front();
        while (!got_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (con_in) pulses++;
            if (cyc == 1 && e.lat > 1) begin
                check("ra_sel", e.idx, {28'd0, ra_sel}, {28'd0, e.ra});
                check("ra_out", e.idx, {31'd0, ra_out}, 32'd1);
            end
            if (done) begin
                got_done = 1'b1;
                check("pc_load", e.idx, {31'd0, pc_load}, {31'd0, e.load});
                if (e.load) check("pc_out", e.idx, pc_out, e.pc_exp);
                check("link_we", e.idx, {31'd0, link_we}, {31'd0, e.lwe});
                if (e.lwe) check("link_data", e.idx, link_data, e.link_exp);
                check("taken", e.idx, {31'd0, taken}, {31'd0, e.tkn});
                check("err", e.idx, {31'd0, err}, {31'd0, e.er});
            end
        end
        check("done_seen", e.idx, {31'd0, got_done}, 32'd1);
        check("latency", e.idx, cyc, e.lat);
        check("con_in_pulses", e.idx, pulses, e.pulses);
        @(negedge clk);
        check("idle_busy", e.idx, {31'd0, busy}, 32'd0);
        check("taken_hold", e.idx, {31'd0, taken}, {31'd0, e.tkn});
        check("err_hold", e.idx, {31'd0, err}, {31'd0, e.er});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit busy_exp[7];
        bit done_exp[7];
        int seen_load;
        int seen_done;

        reset_n = 1'b0; start = 1'b0; ir = '0; pc_in = '0; ra_data = '0; con = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 0, {31'd0, busy}, 32'd0);
        check("rst_done", 0, {31'd0, done}, 32'd0);
        check("rst_pc_load", 0, {31'd0, pc_load}, 32'd0);
        check("rst_pc_out", 0, pc_out, 32'd0);
        check("rst_link_data", 0, link_data, 32'd0);
        check("rst_ra_sel", 0, {28'd0, ra_sel}, 32'd0);
        check("rst_taken", 0, {31'd0, taken}, 32'd0);
        check("rst_err", 0, {31'd0, err}, 32'd0);
        check("rst_con_in", 0, {31'd0, con_in}, 32'd0);
        reset_n = 1'b1;

        vecs[0] = mk(OP_BR, 4'd2, 19'h00010, 32'h100, 32'h0, 1'b1, 3, 1'b1, 32'h110, 1'b0, 32'h0, 1'b1, 1'b0);
        vecs[1] = mk(OP_BR, 4'd1, 19'h7FFF0, 32'h8, 32'h0, 1'b1, 3, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk(OP_BR, 4'd1, 19'h7FFF0, 32'h8, 32'h0, 1'b0, 3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        if (LINK) begin
            vecs[3] = mk(OP_JAL, 4'd5, 19'h0, 32'h44, 32'h2000, 1'b0, 2, 1'b1, 32'h2000, 1'b1, 32'h44, 1'b1, 1'b0);
            vecs[4] = mk(OP_JR, 4'd3, 19'h0, 32'h50, 32'h1234, 1'b0, 2, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b1, 1'b0);
        end else begin
            vecs[3] = mk(OP_JAL, 4'd5, 19'h0, 32'h44, 32'h2000, 1'b0, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            vecs[4] = mk(OP_JR, 4'd3, 19'h0, 32'h50, 32'h1234, 1'b0, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        vecs[5] = mk(5'b00000, 4'd0, 19'h0, 32'h10, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[6] = mk(5'b11111, 4'd7, 19'h5, 32'h20, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[7] = mk(OP_BR, 4'd9, 19'h40000, 32'h40000, 32'h0, 1'b1, 3, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        vecs[8] = mk(OP_BR, 4'd15, 19'h3FFFF, 32'h0, 32'h0, 1'b1, 3, 1'b1, 32'h3FFFF, 1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], i);
            check_output();
        end

        // start held high: the second br is taken only in the single idle cycle after done
        busy_exp = '{1, 1, 1, 0, 1, 1, 1};
        done_exp = '{0, 0, 1, 0, 0, 0, 1};
        @(negedge clk);
        ir = {OP_BR, 4'd4, 4'b0000, 19'h00004}; pc_in = 32'h200; con = 1'b1; start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("held_busy", c + 1, {31'd0, busy}, {31'd0, busy_exp[c]});
            check("held_done", c + 1, {31'd0, done}, {31'd0, done_exp[c]});
            if (c == 6) check("held_pc_out", c + 1, pc_out, 32'h204);
            if (c == 4) start = 1'b0;
        end

        // reset during DECIDE must abort without any PC write
        @(negedge clk);
        ir = {OP_BR, 4'd2, 4'b0000, 19'h00010}; pc_in = 32'h300; con = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_busy", 0, {31'd0, busy}, 32'd0);
        check("rstmid_pc_load", 0, {31'd0, pc_load}, 32'd0);
        check("rstmid_done", 0, {31'd0, done}, 32'd0);
        check("rstmid_taken", 0, {31'd0, taken}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_load = 0;
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (pc_load) seen_load++;
            if (done) seen_done++;
        end
        check("rstmid_late_load", 0, seen_load, 0);
        check("rstmid_late_done", 0, seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
